// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Constants and helpers shared by the register file and the datapath that
//   uses it.
//   RF_WIDTH / RF_DEPTH : default operand width and register count.
//   clog2()             : address width needed to index a given entry count.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_WIDTH = 4;
  localparam int RF_DEPTH = 32;

  // Smallest n with 2**n >= value. Never returns less than 1, so that a
  // two-entry file still gets a one-bit address.
  function automatic int clog2(input int value);
    int n;
    n = 1;
    while ((1 << n) < value) n++;
    return n;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
//   One registered read port of the register file.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     i_mem        : flattened storage, entry k at bits [k*WIDTH +: WIDTH]
//     i_wr_legal   : a write that will really update storage on this edge
//     i_waddr      : write address, used for the write-to-read bypass
//     i_wdata      : write data, forwarded on a bypass hit
//     i_re         : read request
//     i_raddr      : read address
//     o_rdata      : registered read data, held while i_re is low
//     o_rvalid     : one-cycle strobe, o_rdata was loaded on the last edge
//     o_range_err  : combinational, active read with an address >= DEPTH
// -----------------------------------------------------------------------------
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] i_mem,
  input  logic                   i_wr_legal,
  input  logic [ADDR_W-1:0]      i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_re,
  input  logic [ADDR_W-1:0]      i_raddr,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_rvalid,
  output logic                   o_range_err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable; the range compare
  // then folds to constant true.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic             w_in_range;
  logic             w_is_zero;
  logic             w_bypass;
  logic [WIDTH-1:0] w_entry;
  logic [WIDTH-1:0] w_next;

  assign w_in_range  = ({1'b0, i_raddr} < DEPTH_L);
  assign w_is_zero   = (ZERO_REG != 0) && (i_raddr == '0);
  // i_wr_legal already excludes out-of-range and hardwired-zero writes, so a
  // hit here always carries data that storage is about to hold.
  assign w_bypass    = i_wr_legal && (i_waddr == i_raddr);
  assign o_range_err = i_re && !w_in_range;

  // DEPTH:1 word selector over the flattened storage.
  always_comb begin
    // NOTE: default assigned before the loop so no path leaves w_entry
    // unassigned; otherwise synthesis infers a latch.
    w_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_raddr == ADDR_W'(i)) w_entry = i_mem[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_next = w_entry;
    if (!w_in_range || w_is_zero) w_next = '0;
    else if (w_bypass)            w_next = i_wdata;
  end

  // NOTE: non-blocking assignments for all clocked state, so every register
  // samples values from before the edge regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_re;
      if (i_re) o_rdata <= w_next;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   DEPTH x WIDTH register file, one synchronous write port and two
//   independent registered read ports with same-edge write bypass, optional
//   hardwired-zero entry 0 and out-of-range address detection.
//   Ports:
//     clk, rst_n                  : clock, asynchronous active-low reset
//     we, waddr, wdata            : write port
//     re_a, raddr_a               : read request / address, port A
//     rdata_a, rvalid_a           : registered data / one-cycle strobe, port A
//     re_b, raddr_b, rdata_b, rvalid_b : same for port B
//     addr_err                    : registered pulse, an active access on the
//                                   previous edge used an address >= DEPTH
// -----------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH*WIDTH-1:0] r_mem;
  logic                   r_addr_err;
  logic                   w_wr_in_range;
  logic                   w_wr_legal;
  logic                   w_wr_err;
  logic                   w_err_a;
  logic                   w_err_b;

  assign w_wr_in_range = ({1'b0, waddr} < DEPTH_L);
  assign w_wr_legal    = we && w_wr_in_range && !((ZERO_REG != 0) && (waddr == '0));
  assign w_wr_err      = we && !w_wr_in_range;

  // Storage. With ZERO_REG=1 entry 0 is never written, so it stays at its
  // reset value of 0 and behaves as a constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset here because every entry must read 0 before
      // its first write; this makes it flops, not an inferred RAM macro.
      r_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_legal && (waddr == ADDR_W'(i))) r_mem[i*WIDTH +: WIDTH] <= wdata;
      end
    end
  end

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mem      (r_mem),
    .i_wr_legal (w_wr_legal),
    .i_waddr    (waddr),
    .i_wdata    (wdata),
    .i_re       (re_a),
    .i_raddr    (raddr_a),
    .o_rdata    (rdata_a),
    .o_rvalid   (rvalid_a),
    .o_range_err(w_err_a)
  );

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mem      (r_mem),
    .i_wr_legal (w_wr_legal),
    .i_waddr    (waddr),
    .i_wdata    (wdata),
    .i_re       (re_b),
    .i_raddr    (raddr_b),
    .o_rdata    (rdata_b),
    .o_rvalid   (rvalid_b),
    .o_range_err(w_err_b)
  );

  // All three range terms fold to 0 when DEPTH == 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_addr_err <= 1'b0;
    else        r_addr_err <= w_wr_err | w_err_a | w_err_b;
  end

  assign addr_err = r_addr_err;

endmodule
